// File: rtl/piso_stream_if.sv
// piso_stream_if: load side (i, ld_valid, ld_ready, lsb_first) and serial side (o, o_valid, o_ready, last, busy) bundle
interface piso_stream_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] i;
  logic ld_valid, ld_ready, lsb_first, o, o_valid, o_ready, last, busy;
  modport master (output i, ld_valid, lsb_first, o_ready, input ld_ready, o, o_valid, last, busy);
  modport slave (input i, ld_valid, lsb_first, o_ready, output ld_ready, o, o_valid, last, busy);
endinterface

// File: rtl/piso_stream.sv
// piso_stream: WIDTH-bit valid/ready PISO serializer; ports c (clk), r (async active-low reset), s (slave bundle: load in, serial out)
module piso_stream #(
  parameter int WIDTH = 4,
  parameter int BACK2BACK = 1
) (
  input logic c,
  input logic r,
  piso_stream_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q;
  logic [WIDTH-1:0] q_q;
  logic dir_q;
  logic [CW-1:0] cnt_q;
  logic fin, load, beat;
  assign s.o_valid = state_q == SHIFT;
  assign s.busy = s.o_valid;
  assign fin = s.o_valid & (cnt_q == '0);
  assign s.last = fin;
  assign s.o = s.o_valid & (dir_q ? q_q[0] : q_q[WIDTH-1]);
  assign s.ld_ready = (state_q == IDLE) | ((BACK2BACK != 0) & fin & s.o_ready);
  assign load = s.ld_valid & s.ld_ready;
  assign beat = s.o_valid & s.o_ready;
  always_ff @(posedge c or negedge r)
    if (!r) begin
      state_q <= IDLE;
      q_q <= '0;
      dir_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      state_q <= SHIFT;
      q_q <= s.i;
      dir_q <= s.lsb_first;
      cnt_q <= CW'(WIDTH - 1);
    end else if (beat && fin) begin
      state_q <= IDLE;
      q_q <= '0;
    end else if (beat) begin
      q_q <= dir_q ? q_q >> 1 : q_q << 1;
      cnt_q <= cnt_q - CW'(1);
    end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: directed bench with bit-queue reference model for WIDTH=4/B2B=1 and WIDTH=8/B2B=0
module tb_piso_stream;
  logic c = 1'b0;
  logic r;
  int errors = 0;
  int checks = 0;
  int nv;
  bit m4[$];
  bit m8[$];
  bit msb_o[4] = '{1, 1, 0, 1};
  bit lsb_o[7] = '{1, 0, 1, 1, 1, 1, 1};
  bit lsb_rd[7] = '{1, 1, 0, 0, 0, 1, 1};
  bit lsb_ls[7] = '{0, 0, 0, 0, 0, 0, 1};
  bit b2b_o[8] = '{1, 0, 1, 0, 0, 1, 1, 0};
  bit b2b_lr[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  bit w8_o[18] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  bit w8_v[18] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit w8_r[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  piso_stream_if #(.WIDTH(4)) a ();
  piso_stream_if #(.WIDTH(8)) b ();
  piso_stream #(.WIDTH(4), .BACK2BACK(1)) d4 (.c(c), .r(r), .s(a.slave));
  piso_stream #(.WIDTH(8), .BACK2BACK(0)) d8 (.c(c), .r(r), .s(b.slave));
  always #5 c = ~c;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge r) begin
    m4.delete();
    m8.delete();
  end
  always @(posedge c)
    if (r) begin
      bit rdy4, rdy8;
      rdy4 = m4.size() == 0 || (m4.size() == 1 && a.o_ready);
      rdy8 = m8.size() == 0;
      if (m4.size() > 0 && a.o_ready) void'(m4.pop_front());
      if (m8.size() > 0 && b.o_ready) void'(m8.pop_front());
      if (a.ld_valid && rdy4) for (int k = 0; k < 4; k++) m4.push_back(a.lsb_first ? a.i[k] : a.i[3-k]);
      if (b.ld_valid && rdy8) for (int k = 0; k < 8; k++) m8.push_back(b.lsb_first ? b.i[k] : b.i[7-k]);
    end
  always @(negedge c) begin
    #1;
    chk("m4_valid", int'(a.o_valid), int'(m4.size() > 0));
    chk("m4_busy", int'(a.busy), int'(m4.size() > 0));
    chk("m4_o", int'(a.o), m4.size() > 0 ? int'(m4[0]) : 0);
    chk("m4_last", int'(a.last), int'(m4.size() == 1));
    chk("m4_ld_ready", int'(a.ld_ready), int'(m4.size() == 0 || (m4.size() == 1 && a.o_ready)));
    chk("m8_valid", int'(b.o_valid), int'(m8.size() > 0));
    chk("m8_busy", int'(b.busy), int'(m8.size() > 0));
    chk("m8_o", int'(b.o), m8.size() > 0 ? int'(m8[0]) : 0);
    chk("m8_last", int'(b.last), int'(m8.size() == 1));
    chk("m8_ld_ready", int'(b.ld_ready), int'(m8.size() == 0));
  end
  initial begin
    r = 1'b0;
    a.ld_valid = 1'b1;
    a.i = 4'hF;
    a.lsb_first = 1'b0;
    a.o_ready = 1'b1;
    b.ld_valid = 1'b0;
    b.i = 8'h00;
    b.lsb_first = 1'b0;
    b.o_ready = 1'b1;
    #1;
    chk("rst_valid0", int'(a.o_valid), 0);
    repeat (3) begin
      @(negedge c);
      #1;
      chk("rst_valid", int'(a.o_valid), 0);
      chk("rst_o", int'(a.o), 0);
      chk("rst_last", int'(a.last), 0);
      chk("rst_busy", int'(a.busy), 0);
      chk("rst_ld_ready", int'(a.ld_ready), 1);
    end
    @(negedge c);
    r = 1'b1;
    a.ld_valid = 1'b0;
    @(negedge c);
    #1;
    chk("rel_no_load", int'(a.o_valid), 0);
    @(negedge c);
    a.ld_valid = 1'b1;
    a.i = 4'b1101;
    a.lsb_first = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge c);
      a.ld_valid = 1'b0;
      #1;
      chk("msb_o", int'(a.o), int'(msb_o[k]));
      chk("msb_last", int'(a.last), int'(k == 3));
    end
    @(negedge c);
    #1;
    chk("msb_done_valid", int'(a.o_valid), 0);
    chk("msb_done_ld_ready", int'(a.ld_ready), 1);
    a.ld_valid = 1'b1;
    a.i = 4'b1101;
    a.lsb_first = 1'b1;
    nv = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge c);
      a.ld_valid = 1'b0;
      a.o_ready = lsb_rd[k];
      #1;
      chk("lsb_o", int'(a.o), int'(lsb_o[k]));
      chk("lsb_last", int'(a.last), int'(lsb_ls[k]));
      nv += int'(a.o_valid);
    end
    @(negedge c);
    a.o_ready = 1'b1;
    #1;
    nv += int'(a.o_valid);
    chk("lsb_valid_cycles", nv, 7);
    a.ld_valid = 1'b1;
    a.i = 4'b1010;
    a.lsb_first = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge c);
      a.ld_valid = k < 4;
      a.i = 4'b0110;
      a.lsb_first = 1'b1;
      #1;
      chk("b2b_o", int'(a.o), int'(b2b_o[k]));
      chk("b2b_valid", int'(a.o_valid), 1);
      chk("b2b_ld_ready", int'(a.ld_ready), int'(b2b_lr[k]));
    end
    @(negedge c);
    #1;
    chk("b2b_done", int'(a.o_valid), 0);
    a.ld_valid = 1'b1;
    a.i = 4'b1111;
    a.lsb_first = 1'b0;
    @(negedge c);
    a.ld_valid = 1'b0;
    #1;
    chk("mid_bit0", int'(a.o), 1);
    @(negedge c);
    #1;
    chk("mid_bit1", int'(a.o), 1);
    @(negedge c);
    #3;
    r = 1'b0;
    #1;
    chk("mid_async_valid", int'(a.o_valid), 0);
    chk("mid_async_o", int'(a.o), 0);
    chk("mid_async_busy", int'(a.busy), 0);
    @(negedge c);
    r = 1'b1;
    #1;
    chk("mid_rel_ld_ready", int'(a.ld_ready), 1);
    repeat (3) begin
      @(negedge c);
      #1;
      chk("mid_no_residue", int'(a.o_valid), 0);
    end
    b.ld_valid = 1'b1;
    b.i = 8'hA5;
    b.lsb_first = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge c);
      b.i = 8'h3C;
      b.ld_valid = k < 9;
      #1;
      chk("w8_o", int'(b.o), int'(w8_o[k]));
      chk("w8_valid", int'(b.o_valid), int'(w8_v[k]));
      chk("w8_ld_ready", int'(b.ld_ready), int'(w8_r[k]));
    end
    repeat (2) @(negedge c);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serializer; next generation of the 4-bit load/shift PISO.
- Accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per accepted serial beat, MSB-first or LSB-first per word.
- Serial side has valid/ready backpressure, a last-bit flag and optional zero-bubble back-to-back reload.
- Sits between a parallel producer (register file, FIFO) and a serial link or shift chain.

Parameters:
WIDTH, 4, parallel word width in bits; legal range >= 2.
BACK2BACK, 1, 1 = a new word may load on the cycle the last bit is accepted; 0 = at least one idle cycle between words.

Ports:
c  input  1  clock; all state updates on posedge.
r  input  1  asynchronous active-low reset; 0 = reset.
i  input  WIDTH  parallel data word.
ld_valid  input  1  producer has a word on i.
ld_ready  output  1  block can accept a word this cycle.
lsb_first  input  1  sampled with the word: 0 = MSB first, 1 = LSB first.
o  output  1  current serial bit.
o_valid  output  1  o holds a valid bit.
o_ready  input  1  serial sink accepts o this cycle.
last  output  1  o is the final bit of the word.
busy  output  1  word in flight (equals o_valid).

Behaviour:
- State: shift register q[WIDTH-1:0], direction flag dir, bit counter cnt ($clog2(WIDTH) bits), FSM state {IDLE, SHIFT}.
- Reset (r=0, asynchronous, immediate): state=IDLE, q=0, dir=0, cnt=0. Outputs: o=0, o_valid=0, last=0, busy=0, ld_ready=1.
  - Reset mid-word discards the word without completing it.
  - First load is possible on the first posedge after r deasserts.
- Load accept: ld_valid & ld_ready at posedge. Then q<=i, dir<=lsb_first, cnt<=WIDTH-1, state<=SHIFT.
- ld_ready (combinational):
  - 1 in IDLE.
  - In SHIFT: 1 only when BACK2BACK=1 & last=1 & o_ready=1; otherwise 0.
  - i and ld_valid are ignored whenever ld_ready=0.
- Serial output (combinational from registers):
  - o_valid = (state==SHIFT).
  - o = q[WIDTH-1] if dir=0, q[0] if dir=1, gated to 0 when o_valid=0.
  - last = o_valid & (cnt==0).
  - Latency: the first bit appears the cycle after the load edge.
- Beat = o_valid & o_ready at posedge. On a beat with cnt!=0:
  - Shift q left (dir=0) or right (dir=1), filling with 0.
  - cnt<=cnt-1.
- Beat with cnt==0 (last bit):
  - If a new load is accepted at the same edge (BACK2BACK=1 only), the load takes priority: q, dir and cnt are reloaded and state stays SHIFT. There is no bubble; the bit stream is continuous.
  - Otherwise state<=IDLE and q<=0.
- o_ready=0 in SHIFT: q, cnt, dir, o and last all hold (stall of any length). ld_ready stays 0.
- o_ready may be high while o_valid=0; it has no effect.
- BACK2BACK=0: after the last beat the block spends at least one cycle in IDLE with ld_ready=1 before the next word's first bit.
- Throughput: WIDTH bits per WIDTH cycles with BACK2BACK=1 and o_ready held high. With BACK2BACK=0 it is WIDTH bits per WIDTH+1 cycles.
- No X on any output after reset, regardless of X on i while ld_ready=0.

Test Plan:
- Reset: hold r=0 with ld_valid=1 and i=4'hF, release at a negedge. Required: o=0, o_valid=0, last=0, busy=0, ld_ready=1 throughout reset. No load occurs until the first posedge after release.
- MSB-first, WIDTH=4: load i=4'b1101, lsb_first=0, o_ready=1. Required: o=1,1,0,1 on the 4 following cycles, last=1 only on the 4th, then o_valid=0 and ld_ready=1.
- LSB-first with stall: load i=4'b1101, lsb_first=1. Drop o_ready for 3 cycles after the 2nd bit. Required: o=1,0,1,1 in order. o and last are held during the stall. Total 7 cycles with o_valid=1.
- Back-to-back (BACK2BACK=1): load 4'b1010 MSB-first, then hold ld_valid=1 with i=4'b0110, lsb_first=1. Required: ld_ready=1 only on the last-bit cycle. Continuous 8-bit stream 1,0,1,0,0,1,1,0 with no o_valid gap.
- Reset mid-word: load 4'b1111, assert r=0 asynchronously (between edges) after 2 bits. Required: o_valid and o drop to 0 immediately, not at the next edge. After release ld_ready=1 and no residual bits are emitted.
- WIDTH=8, BACK2BACK=0: load 8'hA5 MSB-first, then offer 8'h3C immediately. Required: bits 1,0,1,0,0,1,0,1. At least one IDLE cycle with o_valid=0 and ld_ready=1 before 8'h3C's first bit.
